// File: rtl/nibble_serial_adder.sv
// Wide operand adder that sequences a 4-bit ripple-carry slice one nibble per clock, LSB first.
// Optional signed-overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_d;
    logic              in_ready_d, out_valid_d;
    logic [W-1:0]      a_q, b_q;
    logic              carry;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        slice_a, slice_b, slice_s;
    logic              slice_co;
    logic              accept, last;

    // Behavioural model of the 4-bit ripple-carry slice: returns {Cout[3], S}.
    function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic ci);
        logic       c;
        logic [3:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    // Two's-complement overflow of the slice: Cout[3] ^ Cout[2].
    function automatic logic slice_ovf(input logic [3:0] x, input logic [3:0] y,
                                       input logic ci);
        logic [3:0] co;
        logic       c;
        c  = ci;
        co = '0;
        for (int i = 0; i < 4; i++) begin
            co[i] = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
            c     = co[i];
        end
        return co[3] ^ co[2];
    endfunction
`endif

    assign accept  = in_valid & in_ready;
    assign last    = (state == RUN) && (idx == LAST_IDX);
    assign slice_a = a_q[4*idx +: 4];
    assign slice_b = b_q[4*idx +: 4];
    assign {slice_co, slice_s} = slice_add(slice_a, slice_b, carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so that neither is asserted during reset.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                carry <= cin;
                idx   <= '0;
                sum   <= '0;
            end
        end else if (state == RUN) begin
            sum[4*idx +: 4] <= slice_s;
            carry           <= slice_co;
            idx             <= idx + 1'b1;
            if (last) begin
                cout <= slice_co;
            end
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last) begin
            ovf <= slice_ovf(slice_a, slice_b, carry);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4): latency, handshake, backpressure, reset abort.
module tb_nibble_serial_adder;

    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one operation, checks exact latency and result, optionally holds backpressure.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic [15:0] es, input logic ec,
                          input logic eo, input int hold);
        chk({tag, ".in_ready_idle"}, 16'(in_ready), 16'd1);
        a = av; b = bv; cin = ci; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            chk({tag, ".run_out_valid"}, 16'(out_valid), 16'd0);
            chk({tag, ".run_in_ready"}, 16'(in_ready), 16'd0);
            step();
        end
        chk({tag, ".out_valid"}, 16'(out_valid), 16'd1);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, 16'(cout), 16'(ec));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        chk({tag, ".ovf"}, 16'(ovf), 16'(eo));
`else
        if (eo === 1'bx) $display("note: ovf expectation unknown for %s", tag);
`endif
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ".hold_out_valid"}, 16'(out_valid), 16'd1);
            chk({tag, ".hold_in_ready"}, 16'(in_ready), 16'd0);
            chk({tag, ".hold_sum"}, sum, es);
            chk({tag, ".hold_cout"}, 16'(cout), 16'(ec));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".post_out_valid"}, 16'(out_valid), 16'd0);
        chk({tag, ".post_in_ready"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", 16'(in_ready), 16'd0);
        chk("reset.out_valid", 16'(out_valid), 16'd0);
        chk("reset.sum", sum, 16'h0000);
        chk("reset.cout", 16'(cout), 16'd0);
        rst_n = 1'b1;
        step();
        chk("first_edge.in_ready", 16'(in_ready), 16'd1);

        run_op("carry_chain", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
        run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("cin", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0);
        run_op("backpressure", 16'hA5A5, 16'h0F0F, 1'b0, 16'hB4B4, 1'b0, 1'b0, 5);

        // in_valid held high with changing operands during RUN
        a = 16'h0102; b = 16'h0304; cin = 1'b0; in_valid = 1'b1;
        step();
        for (int i = 0; i < NIB; i++) begin
            a = a + 16'h1111;
            b = b + 16'h2222;
            chk("held.in_ready", 16'(in_ready), 16'd0);
            chk("held.out_valid", 16'(out_valid), 16'd0);
            step();
        end
        chk("held.out_valid_done", 16'(out_valid), 16'd1);
        chk("held.sum", sum, 16'h0406);
        chk("held.cout", 16'(cout), 16'd0);
        chk("held.in_ready_done", 16'(in_ready), 16'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("held.post_in_ready", 16'(in_ready), 16'd1);
        chk("held.post_out_valid", 16'(out_valid), 16'd0);

        // Reset during the second RUN cycle
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("abort.partial_sum", sum, 16'h0003);
        rst_n = 1'b0;
        #1;
        chk("abort.sum", sum, 16'h0000);
        chk("abort.out_valid", 16'(out_valid), 16'd0);
        chk("abort.in_ready", 16'(in_ready), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort.no_out_valid", 16'(out_valid), 16'd0);
            chk("abort.sum_cleared", sum, 16'h0000);
        end
        run_op("after_abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op("ovf_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-word adder front end that drives the team's 4-bit ripple_carry_adder slice (ports A, B, Cin, S, Cout[3:0]; carry out = Cout[3]) one nibble per clock.
- Latches wide operands through a valid/ready handshake and adds them LSB nibble first, feeding each nibble's carry into the next nibble's Cin.
- Presents the full sum and carry out through a valid/ready output handshake.
- Sits directly upstream of the 4-bit adder: it sequences the adder and consumes the adder's results.

Parameters:
NIBBLES, 4, operand width in nibbles (legal range >= 1); operand width W = 4*NIBBLES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry in to nibble 0
out_valid  output  1  sum and cout are valid
out_ready  input  1  consumer accepts the result
sum  output  W  registered sum
cout  output  1  carry out of the top nibble (Cout[3] of the last slice add)

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=0, out_valid=0, sum=0, cout=0, internal carry=0, nibble index=0.
- The first clk edge after rst_n deasserts sets in_ready=1.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready at an edge latches a, b; carry<=cin; idx<=0; sum<=0; next state is RUN.
- RUN:
  - in_ready=0. in_valid is ignored and operands are not sampled.
  - Each cycle the slice is driven with A=a_q[4*idx+:4], B=b_q[4*idx+:4], Cin=carry.
  - At the edge: sum[4*idx+:4]<=S; carry<=Cout[3]; idx<=idx+1.
  - When idx==NIBBLES-1: cout<=Cout[3], next state is DONE, out_valid<=1.
- DONE:
  - out_valid=1. sum and cout are held stable.
  - out_valid&out_ready at an edge: out_valid<=0, next state is IDLE (in_ready=1 after that edge).
  - out_ready low: hold indefinitely.
- Latency: the acceptance edge is k; out_valid rises at edge k+NIBBLES. The earliest next acceptance is edge k+NIBBLES+2, so throughput is 1 op per NIBBLES+2 cycles.
- sum changes nibble by nibble during RUN. It is only meaningful while out_valid=1.
- Arithmetic: {cout,sum} = a+b+cin modulo 2^(W+1). Wrap-around example: all-ones + 1 gives sum=0, cout=1.
- NIBBLES=1: RUN lasts a single cycle. idx width is max(1, clog2(NIBBLES)).
- Mid-operation reset:
  - A reset in RUN or DONE aborts immediately. The partial sum is discarded (cleared) and no out_valid pulse occurs.
- Handshake rules:
  - out_valid never deasserts without a transfer, except on reset.
  - in_ready and out_valid are never both 1.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), registered alongside cout on the final RUN cycle.
  - ovf = Cout[3] ^ Cout[2] of the top-nibble slice add (two's-complement signed overflow).
  - ovf resets to 0 and is held in DONE like sum.
- Undefined:
  - Port ovf is absent; no extra logic.

Test Plan:
- NIBBLES=4, a=16'h00FF, b=16'h0001, cin=0 -> out_valid at edge k+4, sum=16'h0100, cout=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Then a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum and cout stable, in_ready=0 throughout. Pulse out_ready -> in_ready=1 on the following cycle.
- Keep in_valid=1 with changing a during RUN -> the result reflects only the originally accepted operands; no second acceptance until IDLE.
- Assert rst_n=0 in the 2nd RUN cycle, then release -> out_valid never pulses, sum=0. A new op (a=16'h0003, b=16'h0004) afterwards -> sum=16'h0007.
- With NIBBLE_SERIAL_ADDER_OVF_EN:
  - a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1, cout=0.
  - a=16'hFFFF, b=16'h0001 -> ovf=0, cout=1.
